tensor_core_program_loader: RTL and testbench



---
 rtl/tensor_core_pkg.sv | 20 ++
 rtl/tensor_core_program_loader.sv | 174 +++++++++++++++++
 tb/tb_tensor_core_program_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared definitions for the tensor core instruction path (loader and fetch side).
// No logic of its own; holds widths, depth and the loader state encoding.
// Not applicable: no handshakes live here.
package tensor_core_pkg;

    localparam int INSTR_WORD_WIDTH = 16;
    localparam int INSTR_MEM_DEPTH  = 20001;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_LEN_HI  = 3'd1,
        LD_LEN_LO  = 3'd2,
        LD_DATA_HI = 3'd3,
        LD_DATA_LO = 3'd4,
        LD_CHECK   = 3'd5,
        LD_DONE    = 3'd6,
        LD_ERROR   = 3'd7
    } loader_state_e;

endpackage

// File: rtl/tensor_core_program_loader.sv
// Loads a framed big-endian byte stream into instruction memory with length and XOR checks.
// Latency: LO byte accepted at edge k -> registered write strobe/address/data during cycle k+1.
// Backpressure: byte_ready_out is high in every receiving state, so bytes flow one per cycle; it drops once the frame ends.
module tensor_core_program_loader
    import tensor_core_pkg::*;
#(
    parameter int WORD_WIDTH = INSTR_WORD_WIDTH,
    parameter int DEPTH      = INSTR_MEM_DEPTH,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start_in,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_in,
    output logic                  byte_ready_out,
    output logic                  mem_write_enable_out,
    output logic [ADDR_WIDTH-1:0] mem_write_address_out,
    output logic [WORD_WIDTH-1:0] mem_write_data_out,
    output logic                  busy_out,
    output logic                  load_done_out,
    output logic                  error_out,
    output logic [ADDR_WIDTH:0]   words_loaded_out
);

    loader_state_e           state_q, state_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [7:0]              hi_q, hi_d;
    logic [7:0]              csum_q, csum_d;
    logic [ADDR_WIDTH:0]     words_q, words_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    byte_rdy;
    logic                    byte_fire;
    logic [15:0]             len_full;
    logic                    len_oversize;
    logic [ADDR_WIDTH:0]     words_inc;

    // Ready is a pure function of the registered state.
    always_comb begin
        byte_rdy = 1'b0;
        case (state_q)
            LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CHECK: byte_rdy = 1'b1;
            default:                                                 byte_rdy = 1'b0;
        endcase
    end

    assign byte_fire    = byte_valid_in && byte_rdy;
    assign len_full     = {len_hi_q, byte_in};
    // Length is judged on the full 16-bit header before it is narrowed to the counter width.
    assign len_oversize = 32'(len_full) > 32'(DEPTH);
    assign words_inc    = words_q + (ADDR_WIDTH+1)'(1);

    // Frame parser: header, word assembly, checksum and session bookkeeping.
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        hi_d     = hi_q;
        csum_d   = csum_q;
        words_d  = words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start_in) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    csum_d  = '0;
                    state_d = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (byte_fire) begin
                    len_hi_d = byte_in;
                    csum_d   = csum_q ^ byte_in;
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (byte_fire) begin
                    csum_d = csum_q ^ byte_in;
                    len_d  = (ADDR_WIDTH+1)'(len_full);
                    if (len_oversize) begin
                        err_d   = 1'b1;
                        state_d = LD_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = LD_CHECK;
                    end else begin
                        state_d = LD_DATA_HI;
                    end
                end
            end
            LD_DATA_HI: begin
                if (byte_fire) begin
                    hi_d    = byte_in;
                    csum_d  = csum_q ^ byte_in;
                    state_d = LD_DATA_LO;
                end
            end
            LD_DATA_LO: begin
                if (byte_fire) begin
                    csum_d  = csum_q ^ byte_in;
                    we_d    = 1'b1;
                    addr_d  = words_q[ADDR_WIDTH-1:0];
                    data_d  = WORD_WIDTH'({hi_q, byte_in});
                    words_d = words_inc;
                    state_d = (words_inc == len_q) ? LD_CHECK : LD_DATA_HI;
                end
            end
            LD_CHECK: begin
                if (byte_fire) begin
                    if (byte_in == csum_q) begin
                        done_d  = 1'b1;
                        state_d = LD_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LD_ERROR;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= LD_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
            words_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            hi_q     <= hi_d;
            csum_q   <= csum_d;
            words_q  <= words_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign byte_ready_out        = byte_rdy;
    assign busy_out              = byte_rdy;
    assign mem_write_enable_out  = we_q;
    assign mem_write_address_out = addr_q;
    assign mem_write_data_out    = data_q;
    assign load_done_out         = done_q;
    assign error_out             = err_q;
    assign words_loaded_out      = words_q;

endmodule

// File: tb/tb_tensor_core_program_loader.sv
// Scoreboarded bench for the program loader: frames are decoded by a reference model into expected writes and outcome.
// Latency: stimulus and checking meet only through the expected-write queue.
// Backpressure: byte driver honours byte_ready_out with a bounded wait and can insert bubbles.
module tb_tensor_core_program_loader;
    localparam int AW  = 15;
    localparam int DEP = 20001;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bv    = 1'b0;
    logic [7:0]    bd    = 8'h00;
    logic          rdy;
    logic          we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words;

    tensor_core_program_loader dut (
        .clock_in              (clk),
        .reset_n_in            (rst_n),
        .start_in              (start),
        .byte_valid_in         (bv),
        .byte_in               (bd),
        .byte_ready_out        (rdy),
        .mem_write_enable_out  (we),
        .mem_write_address_out (waddr),
        .mem_write_data_out    (wdata),
        .busy_out              (busy),
        .load_done_out         (done),
        .error_out             (err),
        .words_loaded_out      (words)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];
    int         tests   = 0;
    int         fails   = 0;
    int         strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && we) begin
            strobes++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(waddr), 32'(e.addr));
                check("wr_data", 32'(wdata), 32'(e.data));
            end
        end
    end

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit stray);
        int cnt = 0;
        if (stall) begin
            bv = 1'b0;
            @(negedge clk);
        end
        bv    = 1'b1;
        bd    = b;
        start = stray;
        while (!rdy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got ready 0 expected 1 within 50 cycles");
        end
        @(negedge clk);
        bv    = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", 32'(rdy), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Reference model decodes the frame from the byte-level rules, then drives it.
    task automatic run_frame(input int stall_pct, input int stray_idx, input string tag);
        int         n;
        int         nbytes;
        logic [7:0] x;
        bit         ok;
        bit         over;
        int         s0;
        n      = {frame[0], frame[1]};
        over   = n > DEP;
        nbytes = over ? 2 : frame.size();
        ok     = 1'b0;
        if (!over) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back('{addr: AW'(i), data: {frame[2+2*i], frame[3+2*i]}});
            x = 8'h00;
            for (int i = 0; i < frame.size() - 1; i++) x ^= frame[i];
            ok = (x == frame[frame.size()-1]);
        end
        s0 = strobes;
        do_start();
        for (int i = 0; i < nbytes; i++)
            send_byte(frame[i], ($urandom_range(99) < stall_pct), (i == stray_idx));
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_error"}, 32'(err), 32'(!ok));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(rdy), 32'd0);
        check({tag, "_words"}, 32'(words), over ? 32'd0 : 32'(n));
        check({tag, "_strobes"}, 32'(strobes - s0), over ? 32'd0 : 32'(n));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic build_random(input bit bad);
        int         n;
        logic [7:0] x;
        n = $urandom_range(6);
        frame.delete();
        frame.push_back(8'h00);
        frame.push_back(8'(n));
        for (int i = 0; i < 2 * n; i++) frame.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        if (bad) x ^= 8'(1 + $urandom_range(254));
        frame.push_back(x);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(rdy), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words), 32'd0);
        check("rst_addr_data", {1'b0, waddr, wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(0, -1, "nominal");

        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_frame(0, -1, "badsum");

        frame = '{8'h00, 8'h00, 8'h00};
        run_frame(0, -1, "empty");

        frame = '{8'h4E, 8'h22};
        run_frame(0, -1, "oversize");

        frame = '{8'hFF, 8'hFF};
        run_frame(30, -1, "oversize_max");

        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(100, 3, "stall_stray");

        // Reset asserted between edges after the HI byte of word 1.
        do_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_flags", {done, err, we}, 32'd0);
        check("midrst_words", 32'(words), 32'd0);
        check("midrst_addr_data", {1'b0, waddr, wdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(0, -1, "after_rst");

        for (int t = 0; t < 20; t++) begin
            build_random($urandom_range(3) == 0);
            run_frame(25, ($urandom_range(3) == 0) ? 2 : -1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
